// File: rtl/multimode_ring_counter.sv
// Ring / Johnson counter with direction control, parallel load and self-correction.
// All state changes occur on the falling edge of clk.
module multimode_ring_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] out,
  output logic             wrap,
  output logic             err
);

  logic [WIDTH-1:0] seed;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-2:0] trans;
  logic             legal;
  logic             feed_lo;
  logic             feed_hi;

  always_comb begin
    seed    = mode ? '0 : {{(WIDTH-1){1'b0}}, 1'b1};
    // Johnson inverts the bit that wraps around; ring passes it through.
    feed_lo = mode ? ~out[WIDTH-1] : out[WIDTH-1];
    feed_hi = mode ? ~out[0] : out[0];
    shifted = dir ? {feed_hi, out[WIDTH-1:1]} : {out[WIDTH-2:0], feed_lo};
    trans   = out[WIDTH-2:0] ^ out[WIDTH-1:1];
    if (mode)
      legal = (trans & (trans - 1'b1)) == '0;
    else
      legal = (out != '0) && ((out & (out - 1'b1)) == '0);
  end

  always_ff @(negedge clk) begin
    if (rst) begin
      out  <= seed;
      wrap <= 1'b0;
      err  <= 1'b0;
    end else if (load) begin
      out  <= load_val;
      wrap <= 1'b0;
      err  <= 1'b0;
    end else if (en) begin
      if (!legal) begin
        out  <= seed;
        wrap <= 1'b0;
        err  <= 1'b1;
      end else begin
        out  <= shifted;
        wrap <= (shifted == seed);
        err  <= 1'b0;
      end
    end else begin
      wrap <= 1'b0;
      err  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_multimode_ring_counter.sv
// Self-checking bench for multimode_ring_counter at WIDTH = 2, 4 and 8,
// against a behavioural model built from popcounts and rotations.
module tb_multimode_ring_counter;

  logic        clk = 1'b0;
  logic        rst = 1'b0, en = 1'b0, mode = 1'b0, dir = 1'b0, load = 1'b0;
  logic [31:0] lv = '0;
  logic [1:0]  o2;
  logic [3:0]  o4;
  logic [7:0]  o8;
  logic        w2, w4, w8, e2, e4, e8;

  int unsigned total = 0;
  int unsigned bad = 0;

  logic [31:0] m   [3];
  logic        mw  [3];
  logic        me  [3];
  int unsigned wid [3] = '{2, 4, 8};

  always #5 clk = ~clk;

  multimode_ring_counter #(.WIDTH(2)) u2 (.clk(clk), .rst(rst), .en(en), .mode(mode), .dir(dir),
    .load(load), .load_val(lv[1:0]), .out(o2), .wrap(w2), .err(e2));
  multimode_ring_counter #(.WIDTH(4)) u4 (.clk(clk), .rst(rst), .en(en), .mode(mode), .dir(dir),
    .load(load), .load_val(lv[3:0]), .out(o4), .wrap(w4), .err(e4));
  multimode_ring_counter #(.WIDTH(8)) u8 (.clk(clk), .rst(rst), .en(en), .mode(mode), .dir(dir),
    .load(load), .load_val(lv[7:0]), .out(o8), .wrap(w8), .err(e8));

  // Reference model: returns {wrap, err, next_out}.
  function automatic logic [33:0] mstep(int unsigned w, logic [31:0] cur, logic r, logic ld,
                                         logic e, logic md, logic dr, logic [31:0] val);
    logic [31:0] mask, sd, nxt, inv;
    int unsigned ones, diffs;
    bit ok;
    mask = (32'd1 << w) - 32'd1;
    sd   = md ? 32'd0 : 32'd1;
    if (r) return {2'b00, sd};
    if (ld) return {2'b00, val & mask};
    if (!e) return {2'b00, cur};
    ones = 0;
    diffs = 0;
    for (int i = 0; i < int'(w); i++) if (cur[i]) ones++;
    for (int i = 0; i < int'(w) - 1; i++) if (cur[i] != cur[i+1]) diffs++;
    ok = md ? (diffs <= 1) : (ones == 1);
    if (!ok) return {2'b01, sd};
    inv = md ? 32'd1 : 32'd0;
    if (!dr) nxt = ((cur << 1) | (((cur >> (w - 1)) & 32'd1) ^ inv)) & mask;
    else     nxt = (cur >> 1) | ((((cur & 32'd1) ^ inv)) << (w - 1));
    return {(nxt == sd), 1'b0, nxt};
  endfunction

  function automatic logic [33:0] obs(int k);
    case (k)
      0:       return {w2, e2, 30'd0, o2};
      1:       return {w4, e4, 28'd0, o4};
      default: return {w8, e8, 24'd0, o8};
    endcase
  endfunction

  // Advance one falling edge with the currently driven inputs and update the model.
  task automatic step();
    logic [33:0] r;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      r = mstep(wid[k], m[k], rst, load, en, mode, dir, lv);
      mw[k] = r[33];
      me[k] = r[32];
      m[k]  = r[31:0];
    end
    #1;
  endtask

  task automatic drive(logic r, logic ld, logic e, logic md, logic dr, logic [31:0] v);
    rst = r; load = ld; en = e; mode = md; dir = dr; lv = v;
  endtask

  task automatic test_reset();
    drive(1, 0, 0, 0, 0, 0);
    step();
    total++;
    if ({w4, e4, o4} !== {2'b00, 4'b0001}) begin
      bad++; $display("FAIL reset_ring got=%b%b_%b exp=00_0001", w4, e4, o4);
    end
    drive(1, 0, 1, 1, 0, 32'hff);
    step();
    total++;
    if ({w4, e4, o4} !== {2'b00, 4'b0000}) begin
      bad++; $display("FAIL reset_johnson got=%b%b_%b exp=00_0000", w4, e4, o4);
    end
  endtask

  task automatic test_ring_seq();
    logic [3:0] exp4 [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [33:0] got;
    drive(1, 0, 0, 0, 0, 0);
    step();
    drive(0, 0, 1, 0, 0, 0);
    for (int s = 0; s < 10; s++) begin
      step();
      total++;
      if ({w4, e4, o4} !== {(s % 4 == 3), 1'b0, exp4[s % 4]}) begin
        bad++; $display("FAIL ring_seq step=%0d got=%b%b_%b exp=%b0_%b", s, w4, e4, o4, (s % 4 == 3), exp4[s % 4]);
      end
      for (int k = 0; k < 3; k += 2) begin
        got = obs(k);
        total++;
        if (got !== {mw[k], me[k], m[k]}) begin
          bad++; $display("FAIL ring_seq_w%0d step=%0d got=%h exp=%h", wid[k], s, got, {mw[k], me[k], m[k]});
        end
      end
    end
  endtask

  task automatic test_johnson_seq();
    logic [3:0] up [8] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};
    logic [3:0] dn [8] = '{4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b0111, 4'b0011, 4'b0001, 4'b0000};
    logic [3:0] e;
    logic [33:0] got;
    for (int d = 0; d < 2; d++) begin
      drive(1, 0, 0, 1, d[0], 0);
      step();
      drive(0, 0, 1, 1, d[0], 0);
      for (int s = 0; s < 16; s++) begin
        step();
        e = d ? dn[s % 8] : up[s % 8];
        total++;
        if ({w4, e4, o4} !== {(s % 8 == 7), 1'b0, e}) begin
          bad++; $display("FAIL johnson_seq dir=%0d step=%0d got=%b%b_%b exp=%b0_%b", d, s, w4, e4, o4, (s % 8 == 7), e);
        end
        for (int k = 0; k < 3; k += 2) begin
          got = obs(k);
          total++;
          if (got !== {mw[k], me[k], m[k]}) begin
            bad++; $display("FAIL johnson_seq_w%0d dir=%0d step=%0d got=%h exp=%h", wid[k], d, s, got, {mw[k], me[k], m[k]});
          end
        end
      end
    end
  endtask

  task automatic test_illegal_load();
    drive(0, 1, 0, 0, 0, 32'h6);
    step();
    drive(0, 0, 1, 0, 0, 0);
    step();
    total++;
    if ({w4, e4, o4} !== {2'b01, 4'b0001}) begin
      bad++; $display("FAIL ring_correct got=%b%b_%b exp=01_0001", w4, e4, o4);
    end
    step();
    total++;
    if ({w4, e4, o4} !== {2'b00, 4'b0010}) begin
      bad++; $display("FAIL ring_after_correct got=%b%b_%b exp=00_0010", w4, e4, o4);
    end
    drive(0, 1, 0, 1, 0, 32'h5);
    step();
    drive(0, 0, 1, 1, 0, 0);
    step();
    total++;
    if ({w4, e4, o4} !== {2'b01, 4'b0000}) begin
      bad++; $display("FAIL johnson_correct got=%b%b_%b exp=01_0000", w4, e4, o4);
    end
    drive(0, 1, 0, 1, 0, 32'h3);
    step();
    drive(0, 0, 1, 1, 0, 0);
    step();
    total++;
    if ({w4, e4, o4} !== {2'b00, 4'b0111}) begin
      bad++; $display("FAIL johnson_legal_load got=%b%b_%b exp=00_0111", w4, e4, o4);
    end
  endtask

  task automatic test_dir_reverse_hold();
    drive(1, 0, 0, 0, 0, 0);
    step();
    drive(0, 0, 1, 0, 0, 0);
    step();
    step();
    total++;
    if (o4 !== 4'b0100) begin
      bad++; $display("FAIL rev_setup got=%b exp=0100", o4);
    end
    drive(0, 0, 1, 0, 1, 0);
    step();
    total++;
    if ({w4, e4, o4} !== {2'b00, 4'b0010}) begin
      bad++; $display("FAIL rev_first got=%b%b_%b exp=00_0010", w4, e4, o4);
    end
    step();
    total++;
    if ({w4, e4, o4} !== {2'b10, 4'b0001}) begin
      bad++; $display("FAIL rev_wrap got=%b%b_%b exp=10_0001", w4, e4, o4);
    end
    drive(0, 0, 0, 0, 1, 32'hff);
    for (int s = 0; s < 5; s++) begin
      step();
      total++;
      if ({w4, e4, o4} !== {2'b00, 4'b0001}) begin
        bad++; $display("FAIL hold step=%0d got=%b%b_%b exp=00_0001", s, w4, e4, o4);
      end
    end
  endtask

  task automatic test_priority();
    drive(1, 1, 1, 1, 0, 32'h5);
    step();
    total++;
    if ({w4, e4, o4} !== {2'b00, 4'b0000}) begin
      bad++; $display("FAIL prio_rst got=%b%b_%b exp=00_0000", w4, e4, o4);
    end
    drive(0, 1, 1, 0, 0, 32'h6);
    step();
    total++;
    if ({w4, e4, o4} !== {2'b00, 4'b0110}) begin
      bad++; $display("FAIL prio_load got=%b%b_%b exp=00_0110", w4, e4, o4);
    end
    drive(0, 1, 1, 0, 0, 32'h1);
    step();
    total++;
    if ({w4, e4, o4} !== {2'b00, 4'b0001}) begin
      bad++; $display("FAIL load_seed_nowrap got=%b%b_%b exp=00_0001", w4, e4, o4);
    end
  endtask

  task automatic test_random();
    logic [33:0] got;
    drive(1, 0, 0, 0, 0, 0);
    step();
    for (int s = 0; s < 400; s++) begin
      drive(($urandom_range(0, 39) == 0), ($urandom_range(0, 11) == 0), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 15) == 0) ? ~mode : mode, ($urandom_range(0, 7) == 0) ? ~dir : dir, $urandom);
      step();
      for (int k = 0; k < 3; k++) begin
        got = obs(k);
        total++;
        if (got !== {mw[k], me[k], m[k]}) begin
          bad++; $display("FAIL random_w%0d step=%0d got=%h exp=%h", wid[k], s, got, {mw[k], me[k], m[k]});
        end
        total++;
        if (got[33] && got[32]) begin
          bad++; $display("FAIL wrap_err_both_w%0d step=%0d got=11 exp=not11", wid[k], s);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_ring_seq();
    test_johnson_seq();
    test_illegal_load();
    test_dir_reverse_hold();
    test_priority();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multimode_ring_counter.md
MULTIMODE_RING_COUNTER -- requirements
Module: multimode_ring_counter

Interface
REQ-001 The module SHALL have parameter WIDTH, default 4, meaning the number of counter stages; legal range is 2 to 32.
REQ-002 The module SHALL have port clk, input, 1 bit, the single clock; all state updates occur on the falling edge of clk.
REQ-003 The module SHALL have port rst, input, 1 bit, a synchronous active-high reset sampled on the falling edge of clk.
REQ-004 The module SHALL have port en, input, 1 bit, the advance enable.
REQ-005 The module SHALL have port mode, input, 1 bit: 0 selects ring (one-hot), 1 selects Johnson (twisted ring).
REQ-006 The module SHALL have port dir, input, 1 bit: 0 shifts toward the MSB, 1 shifts toward the LSB.
REQ-007 The module SHALL have port load, input, 1 bit, a synchronous parallel-load strobe.
REQ-008 The module SHALL have port load_val, input, WIDTH bits, the value captured on load.
REQ-009 The module SHALL have port out, output, WIDTH bits, the registered counter state.
REQ-010 The module SHALL have port wrap, output, 1 bit, a registered one-cycle pulse on sequence wrap.
REQ-011 The module SHALL have port err, output, 1 bit, a registered one-cycle pulse when an illegal state is corrected.

Function
REQ-012 The seed SHALL be: ring, out = 1 (only out[0] set); Johnson, out = 0.
REQ-013 Priority per falling edge SHALL be rst > load > en; with none asserted, out holds and wrap = err = 0.
REQ-014 On load, out SHALL take load_val unchanged, even if the value is illegal, with wrap = err = 0.
REQ-015 Ring legality: exactly one bit of out is set; every other value, including all-zero, is illegal.
REQ-016 Johnson legality: at most one adjacent pair (out[i], out[i+1]), i = 0..WIDTH-2, differs in value.
REQ-017 On an en edge with out illegal for the current mode, out SHALL become that mode's seed with err = 1 and wrap = 0; no shift occurs on that edge.
REQ-018 Ring, dir=0, legal: out[0] <= out[WIDTH-1] and out[i] <= out[i-1] for i >= 1.
REQ-019 Ring, dir=1, legal: out[WIDTH-1] <= out[0] and out[i] <= out[i+1] for i < WIDTH-1.
REQ-020 Johnson, dir=0, legal: out[0] <= ~out[WIDTH-1] and out[i] <= out[i-1] for i >= 1.
REQ-021 Johnson, dir=1, legal: out[WIDTH-1] <= ~out[0] and out[i] <= out[i+1] for i < WIDTH-1.
REQ-022 The period SHALL be WIDTH enabled edges in ring mode and 2*WIDTH enabled edges in Johnson mode.
REQ-023 wrap SHALL be 1 on the edge where a legal shift produces the current mode's seed; wrap SHALL be 0 on reset, load or correction, even if the result equals the seed.
REQ-024 Changes to mode or dir SHALL take effect on the next enabled edge; legality is judged against the new mode (REQ-017).
REQ-025 A dir change mid-sequence SHALL reverse traversal from the current state without a correction or a skipped state.
REQ-026 The outputs wrap and err SHALL never both be 1 on the same edge.

Reset
REQ-027 On rst, out SHALL take the seed of the mode sampled on that edge, with wrap = 0 and err = 0, regardless of en, load or load_val.
REQ-028 A reset asserted mid-sequence SHALL take effect on that falling edge; counting resumes from the seed on the first enabled edge after rst deasserts.
REQ-029 Before the first reset, out is undefined; the bench SHALL apply rst for at least one falling edge before checking outputs.

Verification
REQ-030 WIDTH=4, mode=0, dir=0, en=1 after reset: out 0001 -> 0010 -> 0100 -> 1000 -> 0001, with wrap = 1 only on the edge that returns to 0001.
REQ-031 WIDTH=4, mode=1, dir=0: out 0000 -> 0001 -> 0011 -> 0111 -> 1111 -> 1110 -> 1100 -> 1000 -> 0000, with wrap on the eighth edge; the same test with dir=1 gives 0000 -> 1000 -> 1100 -> ... -> 0000.
REQ-032 Load 0110 in ring mode, then en: the first edge gives out = 0001, err = 1, wrap = 0; the following edge gives 0010, err = 0.
REQ-033 Load 0101 in Johnson mode, then en: out = 0000 and err = 1; also load 0011 in Johnson mode, then en: out = 0111 and err = 0.
REQ-034 Ring at 0100, dir toggled to 1: the next edges give 0010 then 0001 (wrap = 1); en=0 with load=0 holds out for 5 edges with wrap = err = 0.
REQ-035 rst, load and en asserted together with mode=1 give out = 0000; load and en together give out = load_val with err = 0; WIDTH=2 and WIDTH=8 repeat REQ-030 and REQ-031.
